// File: rtl/adc_ram_writer_if.sv
// adc_ram_writer_if: trigger/sample inputs and RAM write-port outputs of one adc_ram_writer.
interface adc_ram_writer_if #(
  parameter int LANES  = 16,
  parameter int SMP_W  = 10,
  parameter int ADDR_W = 13
);
  logic                   trg;
  logic                   abort;
  logic                   smp_vld;
  logic [SMP_W-1:0]       smp_dat;
  logic                   ram_wen;
  logic [ADDR_W-1:0]      ram_wadrs;
  logic [LANES*SMP_W-1:0] ram_wdat;
  logic                   busy;
  logic                   done;
  logic                   ovf;
  modport master (
    output trg, abort, smp_vld, smp_dat,
    input  ram_wen, ram_wadrs, ram_wdat, busy, done, ovf
  );
  modport slave (
    input  trg, abort, smp_vld, smp_dat,
    output ram_wen, ram_wadrs, ram_wdat, busy, done, ovf
  );
endinterface

// File: rtl/adc_ram_writer.sv
// adc_ram_writer: packs 10-bit ADC samples 16 per word and writes one DEPTH-word frame from address 0.
// Define ADC_RAM_WRITER_TESTPAT_EN to replace sample data with an internal per-frame ramp.
module adc_ram_writer #(
  parameter int LANES  = 16,
  parameter int SMP_W  = 10,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic           clk_250MHz,
  input  logic           rst_n,
  adc_ram_writer_if.slave bus
);
  localparam int LW = $clog2(LANES);
  localparam int WW = ADDR_W + 1;
  localparam int DW = LANES * SMP_W;
  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;
  state_t            state_q, state_d;
  logic              trg_q;
  logic [LW-1:0]     lane_q, lane_d;
  logic [WW-1:0]     word_q, word_d;
  logic [DW-1:0]     pack_q, pack_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] wadrs_q, wadrs_d;
  logic [DW-1:0]     wdat_q, wdat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [SMP_W-1:0]  smp;
  logic              trg_edge;
  assign trg_edge = bus.trg & ~trg_q;
`ifdef ADC_RAM_WRITER_TESTPAT_EN
  logic [SMP_W-1:0] ramp_q, ramp_d;
  assign smp = ramp_q;
  // Ramp value is irrelevant in IDLE, so holding it at zero there gives the clear-on-frame-start.
  always_comb
    ramp_d = (state_q == IDLE) ? '0 :
             (state_q == CAPTURE && bus.smp_vld && !bus.abort) ? ramp_q + 1'b1 : ramp_q;
  always_ff @(posedge clk_250MHz or negedge rst_n)
    if (!rst_n) ramp_q <= '0;
    else        ramp_q <= ramp_d;
`else
  assign smp = bus.smp_dat;
`endif
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    pack_d  = pack_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE:
        if (trg_edge && !bus.abort) begin
          state_d = CAPTURE;
          lane_d  = '0;
          word_d  = '0;
          ovf_d   = 1'b0;
        end
      CAPTURE:
        if (bus.abort) state_d = IDLE;
        else if (bus.smp_vld) begin
          pack_d[lane_q*SMP_W +: SMP_W] = smp;
          lane_d  = lane_q + 1'b1;
          state_d = (lane_q == LW'(LANES-1)) ? FLUSH : CAPTURE;
        end
      FLUSH: begin
        word_d  = word_q + 1'b1;
        lane_d  = '0;
        ovf_d   = ovf_q | bus.smp_vld;
        state_d = bus.abort ? IDLE : (word_q + 1'b1 == WW'(DEPTH)) ? DONE : CAPTURE;
      end
      default: state_d = IDLE;
    endcase
    wen_d   = (state_d == FLUSH);
    wadrs_d = (state_d == FLUSH) ? word_q[ADDR_W-1:0] : wadrs_q;
    wdat_d  = (state_d == FLUSH) ? pack_d : wdat_q;
    busy_d  = (state_d == CAPTURE);
    done_d  = (state_d == DONE);
  end
  always_ff @(posedge clk_250MHz or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      trg_q   <= 1'b0;
      lane_q  <= '0;
      word_q  <= '0;
      pack_q  <= '0;
      wen_q   <= 1'b0;
      wadrs_q <= '0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trg_q   <= bus.trg;
      lane_q  <= lane_d;
      word_q  <= word_d;
      pack_q  <= pack_d;
      wen_q   <= wen_d;
      wadrs_q <= wadrs_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  assign bus.ram_wen   = wen_q;
  assign bus.ram_wadrs = wadrs_q;
  assign bus.ram_wdat  = wdat_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_adc_ram_writer.sv
// tb_adc_ram_writer: directed bench; dut_a has DEPTH=2, dut_b has DEPTH=1, both fed the same stimulus.
module tb_adc_ram_writer;
  localparam int DW = 160;
`ifdef ADC_RAM_WRITER_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif
  typedef struct {
    logic          t, ab, v;
    logic [9:0]    d;
    logic          wen;
    logic [12:0]   adrs;
    logic [DW-1:0] wdat;
    logic          busy, done, ovf;
  } vec_t;
  logic       clk = 1'b0, rst_n = 1'b0, trg = 1'b0, abort = 1'b0, vld = 1'b0;
  logic [9:0] dat = '0;
  always #2 clk = ~clk;
  adc_ram_writer_if ia ();
  adc_ram_writer_if ib ();
  assign ia.trg = trg;
  assign ia.abort = abort;
  assign ia.smp_vld = vld;
  assign ia.smp_dat = dat;
  assign ib.trg = trg;
  assign ib.abort = abort;
  assign ib.smp_vld = vld;
  assign ib.smp_dat = dat;
  adc_ram_writer #(.DEPTH(2)) dut_a (.clk_250MHz(clk), .rst_n(rst_n), .bus(ia.slave));
  adc_ram_writer #(.DEPTH(1)) dut_b (.clk_250MHz(clk), .rst_n(rst_n), .bus(ib.slave));
  int n_chk = 0, n_fail = 0;
  int wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0;
  logic [12:0]   la_adrs = '0, lb_adrs = '0;
  logic [DW-1:0] la_dat = '0, lb_dat = '0;
  always @(negedge clk) begin
    if (ia.ram_wen) begin wr_a <= wr_a + 1; la_adrs <= ia.ram_wadrs; la_dat <= ia.ram_wdat; end
    if (ib.ram_wen) begin wr_b <= wr_b + 1; lb_adrs <= ib.ram_wadrs; lb_dat <= ib.ram_wdat; end
    if (ia.done) dn_a <= dn_a + 1;
    if (ib.done) dn_b <= dn_b + 1;
  end
  function automatic logic [9:0] sx(int idx, logic [9:0] d);
    return TP ? 10'(idx) : d;
  endfunction
  function automatic logic [DW-1:0] pk(int idx0, logic [9:0] d0, int step);
    logic [DW-1:0] r = '0;
    for (int k = 0; k < 16; k++) r[k*10 +: 10] = sx(idx0 + k, d0 + 10'(step * k));
    return r;
  endfunction
  function automatic vec_t mk(logic t, logic ab, logic v, logic [9:0] d, logic wen, logic [12:0] adrs,
                              logic [DW-1:0] wdat, logic busy, logic done, logic ovf);
    vec_t x;
    x.t = t; x.ab = ab; x.v = v; x.d = d; x.wen = wen; x.adrs = adrs;
    x.wdat = wdat; x.busy = busy; x.done = done; x.ovf = ovf;
    return x;
  endfunction
  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_a(string p, logic wen, logic [12:0] adrs, logic [DW-1:0] wdat,
                       logic busy, logic done, logic ovf);
    chk({p, " wen"}, DW'(ia.ram_wen), DW'(wen));
    chk({p, " adrs"}, DW'(ia.ram_wadrs), DW'(adrs));
    chk({p, " wdat"}, ia.ram_wdat, wdat);
    chk({p, " busy"}, DW'(ia.busy), DW'(busy));
    chk({p, " done"}, DW'(ia.done), DW'(done));
    chk({p, " ovf"}, DW'(ia.ovf), DW'(ovf));
  endtask
  task automatic cyc(logic t, logic ab, logic v, logic [9:0] d);
    trg = t; abort = ab; vld = v; dat = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t tv[$];
    logic [DW-1:0] w0, w1;
    int bw, bd;
    w0 = pk(0, 10'd0, 1);
    w1 = pk(16, 10'd16, 1);
    tv.push_back(mk(1, 0, 0, 10'd0, 0, 13'd0, '0, 1, 0, 0));
    for (int k = 0; k < 16; k++)
      tv.push_back(mk(0, 0, 1, 10'(k), k == 15, 13'd0, (k == 15) ? w0 : '0, k != 15, 0, 0));
    tv.push_back(mk(0, 0, 0, 10'd0, 0, 13'd0, w0, 1, 0, 0));
    for (int k = 0; k < 16; k++)
      tv.push_back(mk(0, 0, 1, 10'(16 + k), k == 15, (k == 15) ? 13'd1 : 13'd0, (k == 15) ? w1 : w0, k != 15, 0, 0));
    tv.push_back(mk(0, 0, 0, 10'd0, 0, 13'd1, w1, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 10'd0, 0, 13'd1, w1, 0, 0, 0));
    // reset values, and samples ignored while idle
    repeat (3) @(posedge clk);
    #1;
    chk_a("reset", 0, 13'd0, '0, 0, 0, 0);
    chk("reset b wen", DW'(ib.ram_wen), '0);
    chk("reset b busy", DW'(ib.busy), '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 10'(i));
    cyc(0, 0, 0, 10'd0);
    chk("idle no write a", DW'(wr_a), '0);
    chk("idle no write b", DW'(wr_b), '0);
    chk("idle busy", DW'(ia.busy), '0);
    // single two-word frame on dut_a
    bd = dn_a;
    foreach (tv[i]) begin
      cyc(tv[i].t, tv[i].ab, tv[i].v, tv[i].d);
      chk_a($sformatf("vec%0d", i), tv[i].wen, tv[i].adrs, tv[i].wdat, tv[i].busy, tv[i].done, tv[i].ovf);
    end
    cyc(0, 0, 0, 10'd0);
    chk("frame writes", DW'(wr_a), DW'(2));
    chk("frame done count", DW'(dn_a - bd), DW'(1));
    // overflow on dut_b: continuous strobes, 17th sample falls in FLUSH
    bw = wr_b; bd = dn_b;
    cyc(1, 0, 1, 10'd0);
    chk("ovf busy", DW'(ib.busy), DW'(1));
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, 10'(i));
      chk($sformatf("ovf wen s%0d", i), DW'(ib.ram_wen), DW'(i == 15));
    end
    chk("ovf wdat", ib.ram_wdat, w0);
    chk("ovf adrs", DW'(ib.ram_wadrs), '0);
    cyc(0, 0, 1, 10'd16);
    chk("ovf set", DW'(ib.ovf), DW'(1));
    chk("ovf done", DW'(ib.done), DW'(1));
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 10'(17 + i));
    chk("ovf sticky", DW'(ib.ovf), DW'(1));
    chk("ovf write count", DW'(wr_b - bw), DW'(1));
    chk("ovf done count", DW'(dn_b - bd), DW'(1));
    chk("ovf logged adrs", DW'(lb_adrs), '0);
    chk("ovf logged wdat", lb_dat, w0);
    cyc(0, 1, 0, 10'd0);
    cyc(0, 0, 0, 10'd0);
    // abort at k=7 of the second word on dut_a
    bw = wr_a; bd = dn_a;
    cyc(1, 0, 0, 10'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 10'(i));
    cyc(0, 0, 0, 10'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 10'(16 + i));
    cyc(0, 1, 0, 10'd0);
    chk("abort busy", DW'(ia.busy), '0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 10'd0);
    chk("abort write count", DW'(wr_a - bw), DW'(1));
    chk("abort no done", DW'(dn_a - bd), '0);
    chk("abort ovf cleared on entry", DW'(ia.ovf), '0);
    cyc(1, 1, 0, 10'd0);
    chk("abort beats trg", DW'(ia.busy), '0);
    cyc(1, 0, 0, 10'd0);
    chk("held trg no edge", DW'(ia.busy), '0);
    cyc(0, 0, 0, 10'd0);
    cyc(1, 0, 0, 10'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 10'(100 + i));
    chk_a("restart", 1, 13'd0, pk(0, 10'd100, 1), 0, 0, 0);
    cyc(0, 1, 0, 10'd0);
    cyc(0, 0, 0, 10'd0);
    // constant sample value, two single-word frames on dut_b
    bw = wr_b;
    for (int f = 0; f < 2; f++) begin
      cyc(1, 0, 0, 10'd0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 10'h3FF);
      chk($sformatf("const frame%0d wen", f), DW'(ib.ram_wen), DW'(1));
      chk($sformatf("const frame%0d wdat", f), ib.ram_wdat, pk(0, 10'h3FF, 0));
      cyc(0, 0, 0, 10'd0);
      cyc(0, 0, 0, 10'd0);
    end
    chk("const write count", DW'(wr_b - bw), DW'(2));
    cyc(0, 1, 0, 10'd0);
    cyc(0, 0, 0, 10'd0);
    // asynchronous reset for half a cycle in the middle of a frame
    cyc(1, 0, 0, 10'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 10'(i));
    chk("pre-reset busy", DW'(ia.busy), DW'(1));
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_a("async reset", 0, 13'd0, '0, 0, 0, 0);
    rst_n = 1'b1;
    bw = wr_a;
    cyc(0, 0, 0, 10'd0);
    cyc(1, 0, 0, 10'd0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 10'(50 + i));
    chk_a("post-reset", 1, 13'd0, pk(0, 10'd50, 1), 0, 0, 0);
    cyc(0, 0, 0, 10'd0);
    chk("post-reset write count", DW'(wr_a - bw), DW'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_ram_writer.md
Name: adc_ram_writer

Overview:
- Write-side producer for one adc_ram instance (160-bit word, 13-bit address).
- Packs a serial stream of 10-bit ADC samples into 16-sample words and writes one frame of DEPTH words starting at address 0.
- One instance per RAM (eight in total). These instances drive the adcN_ram write ports that matrix_adc_top later reads through adc_adr.

Parameters:
- LANES, 16, number of samples packed per RAM word.
- SMP_W, 10, bits per sample.
- ADDR_W, 13, RAM address width.
- DEPTH, 5120, words per frame. Legal range is 1..2^ADDR_W.

Ports:
- clk_250MHz  input  1  system clock; every register updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- trg  input  1  frame start, active high, rising-edge detected.
- abort  input  1  synchronous, active high; cancels a frame in progress.
- smp_vld  input  1  sample strobe; one sample is accepted per cycle it is high.
- smp_dat  input  SMP_W  sample value.
- ram_wen  output  1  RAM write enable, one-cycle pulse per word.
- ram_wadrs  output  ADDR_W  RAM write address.
- ram_wdat  output  LANES*SMP_W  packed RAM write data.
- busy  output  1  high while in CAPTURE.
- done  output  1  one-cycle pulse when a frame completes.
- ovf  output  1  sticky flag: a sample arrived in the cycle a word was being flushed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - ram_wen=0, ram_wadrs=0, ram_wdat=0, busy=0, done=0, ovf=0.
  - Lane counter, word counter and the trg edge register clear to 0.
  - A reset during a frame discards the partial word and the frame. No done pulse is issued.
- States: IDLE, CAPTURE, FLUSH, DONE.
- IDLE:
  - smp_vld is ignored.
  - A trg rising edge (trg=1 and the registered trg=0) moves to CAPTURE next cycle.
  - Entering CAPTURE clears lane count, word count and ovf.
- CAPTURE:
  - busy=1.
  - Each cycle with smp_vld=1 stores smp_dat into lane k of the pack register at bits [k*SMP_W +: SMP_W], then increments k. Lane 0 is the first sample, in the LSBs.
  - When the 16th sample (k=15) is accepted, the next state is FLUSH.
- FLUSH (exactly one cycle):
  - ram_wen=1, ram_wdat=pack register, ram_wadrs=word count.
  - Word count increments and k clears.
  - If word count+1 == DEPTH, the next state is DONE; otherwise CAPTURE.
  - smp_vld=1 during FLUSH: the sample is dropped and ovf is set.
  - Latency: ram_wen is high in the cycle after the cycle that accepted the 16th sample.
- DONE (one cycle): done=1, busy=0, then IDLE.
- Output timing: ram_wen, ram_wadrs and ram_wdat are registered. ram_wen is 0 outside FLUSH. ram_wadrs and ram_wdat hold their last values.
- trg:
  - trg is ignored in CAPTURE, FLUSH and DONE.
  - A trg edge in the DONE cycle is lost. A new edge is required after IDLE is reached.
- abort:
  - Takes effect in CAPTURE or FLUSH: next state is IDLE and the partial word is discarded.
  - If abort coincides with FLUSH, the FLUSH write still occurs that cycle.
  - No done pulse. ovf is retained.
  - abort has priority over a trg edge in the same cycle.
- Address range: ram_wadrs covers 0..DEPTH-1 and never wraps within a frame. Each new frame restarts at 0.
- ovf clears only on reset or on entry to CAPTURE.

Optional Feature:
- Macro: ADC_RAM_WRITER_TESTPAT_EN.
- When defined:
  - An internal SMP_W-bit ramp replaces smp_dat for every accepted sample.
  - The ramp clears to 0 on entry to CAPTURE and increments per accepted sample, wrapping at 1023.
  - smp_dat is unused; the port remains.
- When undefined: smp_dat is stored as is, and no ramp logic is present.

Test Plan:
- Reset values: hold rst_n=0, then release. All outputs are 0 and the state is IDLE. Asserting smp_vld in IDLE for 20 cycles gives no ram_wen.
- Single frame, DEPTH=2: pulse trg, then drive 32 back-to-back samples valued 0..31, inserting one idle cycle after each 16th sample to respect FLUSH.
  - First write: ram_wen at adrs 0 with wdat lane0=0 … lane15=15.
  - Second write: adrs 1 with lanes 16..31.
  - done pulses once, 1 cycle after the second write. ovf=0.
- Overflow, DEPTH=1: hold smp_vld=1 continuously.
  - The 17th sample lands in FLUSH and is dropped; ovf=1 and stays set.
  - Exactly one write at adrs 0 containing samples 0..15.
- Abort: in the middle of the second word (k=7), pulse abort.
  - Returns to IDLE with no second write and no done.
  - The next trg restarts at adrs 0 with k=0.
- Asynchronous reset mid-frame: drop rst_n for a half-cycle during CAPTURE.
  - Outputs clear immediately.
  - After release, trg starts a fresh frame at adrs 0.
- With ADC_RAM_WRITER_TESTPAT_EN defined and smp_dat=10'h3FF: 16 strobes produce wdat lanes 0..15. A second frame restarts the ramp at 0.
